// File: rtl/miner_pkg.sv
// Shared types and constants for the nonce dispatcher slice.
// The optional NONCE_DISPATCHER_STATS_EN build uses sat_add32 for its hash counter.
package miner_pkg;

   localparam int NONCE_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DISPATCH = 2'd1,
      DRAIN    = 2'd2,
      REPORT   = 2'd3
   } dispatch_state_t;

   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

endpackage

// File: rtl/nonce_dispatcher_if.sv
// Job, core and result signals of the nonce dispatcher; master is the dispatcher side.
// NONCE_DISPATCHER_STATS_EN adds the hash_count output.
interface nonce_dispatcher_if
   import miner_pkg::*;
#(
   parameter int NUM_CORES = 4,
   parameter int NONCE_W   = NONCE_W_DEF
);
   logic                 job_valid;
   logic                 job_ready;
   logic [NONCE_W-1:0]   nonce_start;
   logic [NONCE_W-1:0]   nonce_end;
   logic                 abort;
   logic [NUM_CORES-1:0] core_start;
   logic [NONCE_W-1:0]   core_nonce;
   logic [NUM_CORES-1:0] core_done;
   logic [NUM_CORES-1:0] core_hit;
   logic                 result_valid;
   logic                 result_found;
   logic [NONCE_W-1:0]   result_nonce;
`ifdef NONCE_DISPATCHER_STATS_EN
   logic [31:0]          hash_count;

   modport master (
      input  job_valid, nonce_start, nonce_end, abort, core_done, core_hit,
      output job_ready, core_start, core_nonce, result_valid, result_found, result_nonce,
      output hash_count
   );
   modport slave (
      output job_valid, nonce_start, nonce_end, abort, core_done, core_hit,
      input  job_ready, core_start, core_nonce, result_valid, result_found, result_nonce,
      input  hash_count
   );
`else
   modport master (
      input  job_valid, nonce_start, nonce_end, abort, core_done, core_hit,
      output job_ready, core_start, core_nonce, result_valid, result_found, result_nonce
   );
   modport slave (
      output job_valid, nonce_start, nonce_end, abort, core_done, core_hit,
      input  job_ready, core_start, core_nonce, result_valid, result_found, result_nonce
   );
`endif
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr_i, wrapping.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [PW-1:0] grant_idx_o,
   output logic          any_grant_o
);
   int   pos;
   logic take;

   // Walk the ring once from the pointer; the first requester seen wins.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      any_grant_o = 1'b0;
      pos         = 0;
      take        = 1'b0;
      for (int k = 0; k < N; k++) begin
         pos           = (int'(ptr_i) + k >= N) ? int'(ptr_i) + k - N : int'(ptr_i) + k;
         take          = req_i[pos] && !any_grant_o;
         grant_o[pos]  = take;
         grant_idx_o   = take ? PW'(pos) : grant_idx_o;
         any_grant_o   = any_grant_o | take;
      end
   end

endmodule

// File: rtl/nonce_dispatcher.sv
// Spreads one nonce range over NUM_CORES hash cores, stops on first hit, drains, reports.
// Define NONCE_DISPATCHER_STATS_EN to add the saturating hash_count output.
module nonce_dispatcher
   import miner_pkg::*;
#(
   parameter int NUM_CORES = 4,
   parameter int NONCE_W   = NONCE_W_DEF
) (
   input logic               clk,
   input logic               rst,
   nonce_dispatcher_if.master bus
);
   localparam int PTR_W = $clog2(NUM_CORES);

   dispatch_state_t      state_q, state_d;
   logic [NUM_CORES-1:0] inflight_q, inflight_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [NONCE_W-1:0]   next_nonce_q, next_nonce_d;
   logic [NONCE_W-1:0]   end_q, end_d;
   logic [NONCE_W-1:0]   result_nonce_q, result_nonce_d;
   logic                 found_q, found_d;
   logic [NONCE_W-1:0]   nonce_tab_q [NUM_CORES];
   logic [NONCE_W-1:0]   nonce_tab_d [NUM_CORES];

   logic [NUM_CORES-1:0] grant_s;
   logic [PTR_W-1:0]     grant_idx_s;
   logic                 any_grant_s;
   logic                 job_hs_s, issue_s, last_issue_s, new_hit_s;
   logic [NUM_CORES-1:0] done_acc_s, hit_vec_s;
   logic [PTR_W-1:0]     hit_idx_s, ptr_next_s;

`ifdef NONCE_DISPATCHER_STATS_EN
   logic [31:0]          hash_count_q, hash_count_d, done_cnt_s;
`endif

   rr_arbiter #(.N(NUM_CORES), .PW(PTR_W)) u_arb (
      .req_i       (~inflight_q),
      .ptr_i       (ptr_q),
      .grant_o     (grant_s),
      .grant_idx_o (grant_idx_s),
      .any_grant_o (any_grant_s)
   );

   // Grants look at inflight_q, so a core finishing this cycle is only re-granted next cycle.
   assign job_hs_s     = (state_q == IDLE) && bus.job_valid;
   assign issue_s      = (state_q == DISPATCH) && !bus.abort && any_grant_s;
   assign last_issue_s = issue_s && (next_nonce_q == end_q);
   assign done_acc_s   = (state_q != IDLE) ? (bus.core_done & inflight_q) : '0;
   assign hit_vec_s    = done_acc_s & bus.core_hit;
   assign new_hit_s    = (|hit_vec_s) && !found_q;
   assign ptr_next_s   = (int'(grant_idx_s) == NUM_CORES - 1) ? '0 : grant_idx_s + PTR_W'(1);

   // Lowest-index hit wins when several cores hit together.
   always_comb begin
      hit_idx_s = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         hit_idx_s = hit_vec_s[i] ? PTR_W'(i) : hit_idx_s;
      end
   end

   // Datapath next values.
   always_comb begin
      inflight_d     = (inflight_q & ~done_acc_s) | (issue_s ? grant_s : '0);
      ptr_d          = issue_s ? ptr_next_s : ptr_q;
      next_nonce_d   = job_hs_s ? bus.nonce_start
                                : (issue_s ? next_nonce_q + NONCE_W'(1) : next_nonce_q);
      end_d          = job_hs_s ? bus.nonce_end : end_q;
      found_d        = job_hs_s ? 1'b0 : (found_q | new_hit_s);
      result_nonce_d = new_hit_s ? nonce_tab_q[hit_idx_s] : result_nonce_q;
      for (int i = 0; i < NUM_CORES; i++) begin
         nonce_tab_d[i] = (issue_s && grant_s[i]) ? next_nonce_q : nonce_tab_q[i];
      end
   end

`ifdef NONCE_DISPATCHER_STATS_EN
   // Accepted completions for the current job, saturating.
   always_comb begin
      done_cnt_s = 32'd0;
      for (int i = 0; i < NUM_CORES; i++) begin
         done_cnt_s = done_cnt_s + {31'd0, done_acc_s[i]};
      end
      hash_count_d = job_hs_s ? 32'd0 : sat_add32(hash_count_q, done_cnt_s);
   end
`endif

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     state_d = bus.job_valid ? DISPATCH : IDLE;
         DISPATCH: state_d = (bus.abort || last_issue_s || new_hit_s) ? DRAIN : DISPATCH;
         DRAIN:    state_d = (inflight_d == '0) ? REPORT : DRAIN;
         REPORT:   state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Outputs.
   always_comb begin
      bus.job_ready    = (state_q == IDLE);
      bus.core_start   = issue_s ? grant_s : '0;
      bus.core_nonce   = issue_s ? next_nonce_q : '0;
      bus.result_valid = (state_q == REPORT);
      bus.result_found = (state_q == REPORT) && found_q;
      bus.result_nonce = result_nonce_q;
`ifdef NONCE_DISPATCHER_STATS_EN
      bus.hash_count   = hash_count_q;
`endif
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         inflight_q     <= '0;
         ptr_q          <= '0;
         next_nonce_q   <= '0;
         end_q          <= '0;
         result_nonce_q <= '0;
         found_q        <= 1'b0;
         for (int i = 0; i < NUM_CORES; i++) begin
            nonce_tab_q[i] <= '0;
         end
`ifdef NONCE_DISPATCHER_STATS_EN
         hash_count_q   <= 32'd0;
`endif
      end else begin
         state_q        <= state_d;
         inflight_q     <= inflight_d;
         ptr_q          <= ptr_d;
         next_nonce_q   <= next_nonce_d;
         end_q          <= end_d;
         result_nonce_q <= result_nonce_d;
         found_q        <= found_d;
         for (int i = 0; i < NUM_CORES; i++) begin
            nonce_tab_q[i] <= nonce_tab_d[i];
         end
`ifdef NONCE_DISPATCHER_STATS_EN
         hash_count_q   <= hash_count_d;
`endif
      end
   end

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Scoreboard bench for nonce_dispatcher: behavioural core responders, queue-based reference model.
module tb_nonce_dispatcher;
   localparam int NC = 4;
   localparam int NW = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   nonce_dispatcher_if #(.NUM_CORES(NC), .NONCE_W(NW)) bus ();
   nonce_dispatcher #(.NUM_CORES(NC), .NONCE_W(NW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Core responder configuration
   int          dmode;
   int          fixed_d;
   bit          spur_en;
   bit          hit_en;
   logic [NW-1:0] hit_a, hit_b;
   int          due [NC];
   logic [NW-1:0] held [NC];
   int          issue_ord;

   // Reference model state
   typedef struct { bit found; logic [NW-1:0] nonce; int cnt; } res_t;
   res_t          res_q[$];
   logic [NW-1:0] issue_q[$];
   int            ph;
   logic [NC-1:0] mbusy;
   int            mptr;
   logic [NW-1:0] mtab [NC];
   bit            mfound;
   logic [NW-1:0] mfnonce;
   int            mcnt;
   bit            chk_reset;
   int            n_issued = 0;
   int            n_results = 0;
   bit            last_res_found;
   logic [NW-1:0] last_res_nonce;

   // Behavioural hash cores: done after a delay, hit when the held nonce is a target.
   initial begin
      logic [NC-1:0] done, hit;
      for (int i = 0; i < NC; i++) due[i] = -1;
      bus.core_done = '0;
      bus.core_hit  = '0;
      issue_ord = 0;
      forever begin
         @(posedge clk); #1;
         done = '0;
         hit  = '0;
         for (int i = 0; i < NC; i++) begin
            if (due[i] == cyc) begin
               done[i] = 1'b1;
               hit[i]  = hit_en && (held[i] == hit_a || held[i] == hit_b);
               due[i]  = -1;
            end else if (spur_en && due[i] == -1 && $urandom_range(0, 9) == 0) begin
               done[i] = 1'b1;
               hit[i]  = 1'b1;
            end
         end
         bus.core_done = done;
         bus.core_hit  = hit;
         @(negedge clk);
         if (rst) begin
            for (int i = 0; i < NC; i++) due[i] = -1;
         end else begin
            if (bus.job_valid && bus.job_ready) issue_ord = 0;
            for (int i = 0; i < NC; i++) begin
               if (bus.core_start[i]) begin
                  held[i] = bus.core_nonce;
                  case (dmode)
                     1:       due[i] = cyc + fixed_d;
                     2:       due[i] = cyc + 5 - (issue_ord % 4);
                     default: due[i] = cyc + int'($urandom_range(1, 5));
                  endcase
                  issue_ord++;
               end
            end
         end
      end
   end

   // Monitor + reference model: evaluated once per cycle on the falling edge.
   initial begin
      logic [NC-1:0] busy_prev, exp_start;
      logic [NW-1:0] n;
      int  g;
      bit  last, newhit;
      res_t r;
      ph = 0; mbusy = '0; mptr = 0; mfound = 1'b0; mfnonce = '0; mcnt = 0; chk_reset = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            ph = 0; mbusy = '0; mptr = 0; mfound = 1'b0; mcnt = 0;
            issue_q.delete();
            res_q.delete();
            chk_reset = 1'b1;
            continue;
         end
         if (chk_reset) begin
            chk("rst_job_ready", 64'(bus.job_ready), 64'(1));
            chk("rst_core_start", 64'(bus.core_start), 64'(0));
            chk("rst_result_valid", 64'(bus.result_valid), 64'(0));
            chk("rst_result_found", 64'(bus.result_found), 64'(0));
            chk("rst_result_nonce", 64'(bus.result_nonce), 64'(0));
`ifdef NONCE_DISPATCHER_STATS_EN
            chk("rst_hash_count", 64'(bus.hash_count), 64'(0));
`endif
            chk_reset = 1'b0;
         end
         chk("job_ready", 64'(bus.job_ready), 64'(ph == 0));
         chk("result_valid", 64'(bus.result_valid), 64'(ph == 3));
         if (bus.result_valid) begin
            if (res_q.size() == 0) begin
               chk("unexpected_result", 64'(1), 64'(0));
            end else begin
               r = res_q.pop_front();
               n_results++;
               last_res_found = bus.result_found;
               last_res_nonce = bus.result_nonce;
               chk("result_found", 64'(bus.result_found), 64'(r.found));
               if (r.found) chk("result_nonce", 64'(bus.result_nonce), 64'(r.nonce));
`ifdef NONCE_DISPATCHER_STATS_EN
               chk("hash_count", 64'(bus.hash_count), 64'(r.cnt));
`endif
            end
         end
         // Expected grant: first idle core from the pointer, while dispatching and not aborted.
         busy_prev = mbusy;
         g = -1;
         if (ph == 1 && !bus.abort && issue_q.size() > 0) begin
            for (int k = 0; k < NC; k++) begin
               if (g < 0 && !busy_prev[(mptr + k) % NC]) g = (mptr + k) % NC;
            end
         end
         exp_start = '0;
         if (g >= 0) exp_start[g] = 1'b1;
         chk("core_start", 64'(bus.core_start), 64'(exp_start));
         last = 1'b0;
         if (g >= 0) begin
            n = issue_q.pop_front();
            chk("core_nonce", 64'(bus.core_nonce), 64'(n));
            mtab[g]  = n;
            mbusy[g] = 1'b1;
            mptr     = (g + 1) % NC;
            n_issued++;
            last = (issue_q.size() == 0);
         end
         newhit = 1'b0;
         if (ph != 0) begin
            for (int i = 0; i < NC; i++) begin
               if (bus.core_done[i] && busy_prev[i]) begin
                  mbusy[i] = 1'b0;
                  mcnt++;
                  if (bus.core_hit[i] && !mfound) begin
                     mfound  = 1'b1;
                     mfnonce = mtab[i];
                     newhit  = 1'b1;
                  end
               end
            end
         end
         case (ph)
            0: if (bus.job_valid) begin
                  issue_q.delete();
                  n = bus.nonce_start;
                  for (int k = 0; k < 4096; k++) begin
                     issue_q.push_back(n);
                     if (n == bus.nonce_end) break;
                     n = n + NW'(1);
                  end
                  mfound = 1'b0;
                  mcnt   = 0;
                  ph     = 1;
               end
            1: if (bus.abort || last || newhit) ph = 2;
            2: if (mbusy == '0) begin
                  r.found = mfound; r.nonce = mfnonce; r.cnt = mcnt;
                  res_q.push_back(r);
                  ph = 3;
               end
            default: ph = 0;
         endcase
      end
   end

   task automatic wait_ready(input string name);
      int w = 0;
      while (bus.job_ready !== 1'b1) begin
         if (w > 600) begin
            chk(name, 64'(bus.job_ready), 64'(1));
            return;
         end
         w++;
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic run_job(input logic [NW-1:0] s, input logic [NW-1:0] e,
                          input int abort_at, input int rst_at);
      wait_ready("timeout_job_ready");
      bus.nonce_start = s;
      bus.nonce_end   = e;
      bus.job_valid   = 1'b1;
      @(posedge clk); #1;
      bus.job_valid   = 1'b0;
      if (rst_at >= 0) begin
         repeat (rst_at) begin @(posedge clk); #1; end
         do_reset();
         return;
      end
      if (abort_at >= 0) begin
         repeat (abort_at) begin @(posedge clk); #1; end
         bus.abort = 1'b1;
         @(posedge clk); #1;
         bus.abort = 1'b0;
      end
      wait_ready("timeout_job_done");
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // Directed scenarios first, then randomized jobs.
   initial begin
      int base, rbase, len, ab;
      logic [NW-1:0] s;
      rst = 1'b1;
      bus.job_valid = 1'b0; bus.abort = 1'b0; bus.nonce_start = '0; bus.nonce_end = '0;
      dmode = 1; fixed_d = 3; spur_en = 1'b0; hit_en = 1'b0; hit_a = '0; hit_b = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      base = n_issued; rbase = n_results;
      run_job(32'h10, 32'h17, -1, -1);
      chk("s1_issue_count", 64'(n_issued - base), 64'(8));
      chk("s1_result_count", 64'(n_results - rbase), 64'(1));
      chk("s1_found", 64'(last_res_found), 64'(0));
`ifdef NONCE_DISPATCHER_STATS_EN
      chk("s1_hash_count", 64'(bus.hash_count), 64'(8));
`endif

      hit_en = 1'b1; hit_a = 32'h12; hit_b = 32'h12;
      run_job(32'h10, 32'h17, -1, -1);
      chk("s2_found", 64'(last_res_found), 64'(1));
      chk("s2_nonce", 64'(last_res_nonce), 64'(32'h12));

      do_reset();
      dmode = 2; hit_a = 32'h21; hit_b = 32'h23;
      run_job(32'h20, 32'h27, -1, -1);
      chk("s3_found", 64'(last_res_found), 64'(1));
      chk("s3_nonce", 64'(last_res_nonce), 64'(32'h21));

      dmode = 0; hit_en = 1'b0; base = n_issued;
      run_job(32'hFFFF_FFFE, 32'h0000_0001, -1, -1);
      chk("s4_issue_count", 64'(n_issued - base), 64'(4));
      chk("s4_found", 64'(last_res_found), 64'(0));

      dmode = 1; fixed_d = 6; base = n_issued; rbase = n_results;
      run_job(32'h100, 32'h1FF, 2, -1);
      chk("s5_issue_count", 64'(n_issued - base), 64'(2));
      chk("s5_result_count", 64'(n_results - rbase), 64'(1));
      chk("s5_found", 64'(last_res_found), 64'(0));

      fixed_d = 3;
      run_job(32'h40, 32'h7F, -1, 5);
      base = n_issued;
      run_job(32'h80, 32'h83, -1, -1);
      chk("s6_issue_count", 64'(n_issued - base), 64'(4));

      dmode = 0; spur_en = 1'b1;
      for (int j = 0; j < 40; j++) begin
         s      = NW'($urandom);
         len    = int'($urandom_range(1, 12));
         hit_en = ($urandom_range(0, 1) == 1);
         hit_a  = s + NW'($urandom_range(0, len + 1));
         hit_b  = s + NW'($urandom_range(0, len + 1));
         ab     = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 8)) : -1;
         run_job(s, s + NW'(len - 1), ab, -1);
      end

      repeat (5) begin @(posedge clk); #1; end
      chk("pending_results", 64'(res_q.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/nonce_dispatcher.md
Name: nonce_dispatcher

Overview:
- Schedules one mining job (a nonce range) across NUM_CORES SHA hash cores.
- Issues one nonce per cycle to an idle core, chosen round-robin.
- Tracks which nonce each core holds, stops on the first hit, drains in-flight work, then reports one result to the host-side interface.
- Sits between the job loader and the per-core miner controllers. It replaces per-core nonce incrementing.

Parameters:
NUM_CORES, 4, number of hash cores served (2..16)
NONCE_W, 32, nonce width in bits

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
job_valid  in  1  new job offered
job_ready  out  1  dispatcher can accept a job (IDLE only)
nonce_start  in  NONCE_W  first nonce of range, sampled on job handshake
nonce_end  in  NONCE_W  last nonce of range (inclusive), sampled on job handshake
abort  in  1  cancel current job
core_start  out  NUM_CORES  one-hot, one-cycle start pulse to a core
core_nonce  out  NONCE_W  shared nonce bus, valid only while core_start != 0
core_done  in  NUM_CORES  per-core one-cycle completion pulse
core_hit  in  NUM_CORES  per-core target met, qualified by core_done
result_valid  out  1  one-cycle result pulse
result_found  out  1  a hit occurred (qualified by result_valid)
result_nonce  out  NONCE_W  nonce of the winning core (qualified by result_valid and result_found)

Behaviour:
- Reset values: all outputs 0 except job_ready=1. State IDLE. inflight mask=0. RR pointer=0. Found flag=0.
- IDLE:
  - job_ready=1.
  - On job_valid: latch start/end, next_nonce=start, found=0, go to DISPATCH.
- DISPATCH:
  - Grant goes to the first core with inflight=0, searching from the RR pointer upward with wrap.
  - On a grant g:
    - core_start[g]=1 and core_nonce=next_nonce in the same cycle.
    - nonce_tab[g]=next_nonce; inflight[g] set.
    - RR pointer=g+1 mod NUM_CORES; next_nonce increments mod 2^NONCE_W.
  - If the issued nonce equals the latched end, go to DRAIN. This issue is the last one.
  - Range wrap: if start>end, the range passes through 2^NONCE_W-1 and then 0. start==end is a single nonce.
  - No idle core: no issue, stay in DISPATCH.
- core_done handling, any state except IDLE:
  - core_done[i] clears inflight[i].
  - A core_done[i] arriving with inflight[i]=0 is ignored.
  - A core_done[i] on the cycle the grant would go to i: the done takes effect and core i is not re-granted until the next cycle.
- Hits:
  - core_done[i]&core_hit[i] while found=0: found=1, result_nonce=nonce_tab[i], go to DRAIN.
  - Simultaneous hits: the lowest index wins.
  - Hits after found=1 are ignored.
  - A hit in the same cycle as the last issue still records the hit.
- abort:
  - In DISPATCH: no issue that cycle, go to DRAIN; the found flag is unchanged.
  - In IDLE: ignored.
- DRAIN:
  - No issues.
  - Wait until inflight==0, counting core_done pulses arriving this cycle; then go to REPORT.
- REPORT:
  - result_valid=1 for one cycle with result_found=found.
  - result_nonce is held until the next job handshake. When found=0 its value is don't-care.
  - Go to IDLE.
- Latency: job handshake to first core_start is 1 cycle. Last done to result_valid is 1 cycle.
- rst mid-job forces the reset values at the next edge. The cores must be reset by the same rst.

Optional Feature:
- Macro: NONCE_DISPATCHER_STATS_EN.
- Defined:
  - Adds output hash_count [31:0], counting accepted core_done pulses (inflight=1) for the current job.
  - Cleared on the job handshake. Saturates at 2^32-1.
  - Several dones in one cycle add their popcount.
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

Decomposition:
- miner_pkg:
  - dispatch_state_t enum {IDLE, DISPATCH, DRAIN, REPORT}.
  - Default NONCE_W constant.
- Sub-module rr_arbiter (parameter N):
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, grant index, any_grant.
  - Purely combinational; the pointer register stays in nonce_dispatcher.

Test Plan:
1. NUM_CORES=4, start=0x10, end=0x17, no hits, each core done 3 cycles after its start -> nonces 0x10..0x17 each issued exactly once, cores granted 0,1,2,3,0,... by round-robin; result_valid with result_found=0 after the last done.
2. Same range; core 2 hit on nonce 0x12 -> no issues after the hit cycle; result_found=1, result_nonce=0x12 once all in-flight work has drained.
3. Cores 1 and 3 both hit in the same cycle with nonces 0x21 and 0x23 -> result_nonce=0x21.
4. start=0xFFFFFFFE, end=0x00000001 -> issued sequence FFFFFFFE, FFFFFFFF, 0, 1, then DRAIN.
5. abort during DISPATCH with 2 cores in flight -> no further core_start; result_valid after both dones, result_found=0; job_ready=1 the next cycle.
6. Assert rst mid-DISPATCH -> next cycle all outputs at reset values, job_ready=1; a new job restarts the grants at core 0. With NONCE_DISPATCHER_STATS_EN defined, hash_count equals 8 at the end of scenario 1.
